// File: rtl/led_sched_pkg.sv
// led_sched_pkg: shared state encoding, default timing constants and wrap-search helper.
package led_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, ALERT = 2'd2} state_e;
  localparam int DEF_DWELL_TICKS = 8;
  localparam int DEF_HOLD_TICKS = 16;
  // First set bit of valid strictly after cur (mod n); returns cur when no other bit is set.
  function automatic logic [2:0] next_valid(input logic [7:0] valid, input logic [2:0] cur, input int n);
    logic [2:0] r;
    int idx;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = (int'(cur) + i) % n;
      if (i < n && valid[idx[2:0]]) r = idx[2:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/led_tick_prescaler.sv
// led_tick_prescaler: free-running counter, tick pulses in the cycle after it wraps to zero.
module led_tick_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic sclk,
  input  logic reset,
  output logic tick
);
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  always_comb begin
    cnt_d = cnt_q + PRESCALE_W'(1);
    tick_d = &cnt_q;
  end
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/led_display_sched.sv
// led_display_sched: pages the LED display across sources with alert preemption.
// Optional LED_SCHED_FREEZE_EN adds a freeze input that pauses paging in ROTATE.
module led_display_sched import led_sched_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W = 2,
  parameter int PRESCALE_W = 16,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS,
  parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic [NUM_SRC*16-1:0] src_value,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [NUM_SRC-1:0]    src_alert,
`ifdef LED_SCHED_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic [15:0]           number,
  output logic [SRC_W-1:0]      cur_src,
  output logic                  alert_active,
  output logic                  tick
);
  localparam int CW = $clog2((DWELL_TICKS > HOLD_TICKS ? DWELL_TICKS : HOLD_TICKS) + 1);
  state_e state_q, state_d;
  logic [SRC_W-1:0] cur_q, cur_d, grant, low_valid, nxt_valid;
  logic [CW-1:0] dwell_q, dwell_d, hold_q, hold_d;
  logic [NUM_SRC-1:0] pend_q, pend_d, pend_eff, pend_oth;
  logic [15:0] number_q, number_d;
  logic frozen;
  led_tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (.sclk(sclk), .reset(reset), .tick(tick));
`ifdef LED_SCHED_FREEZE_EN
  assign frozen = freeze && state_q == ROTATE;
`else
  assign frozen = 1'b0;
`endif
  // Alerts arriving this cycle take part in arbitration immediately.
  assign pend_eff = pend_q | src_alert;
  assign pend_oth = pend_eff & ~(NUM_SRC'(1) << cur_q);
  assign grant = SRC_W'(next_valid(8'(pend_eff), 3'(NUM_SRC - 1), NUM_SRC));
  assign low_valid = SRC_W'(next_valid(8'(src_valid), 3'(NUM_SRC - 1), NUM_SRC));
  assign nxt_valid = SRC_W'(next_valid(8'(src_valid), 3'(cur_q), NUM_SRC));
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      dwell_q <= '0;
      hold_q <= '0;
      pend_q <= '0;
      number_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      dwell_q <= dwell_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      number_q <= number_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    dwell_d = dwell_q;
    hold_d = hold_q;
    pend_d = pend_eff;
    number_d = state_q == IDLE ? 16'h0000 : frozen ? number_q : src_value[16*cur_q +: 16];
    if (state_q == ALERT) begin
      pend_d = pend_oth;
      if (src_alert[cur_q]) hold_d = '0;
      else if (tick && hold_q != CW'(HOLD_TICKS - 1)) hold_d = hold_q + CW'(1);
      else if (tick) begin
        if (|pend_oth) begin
          cur_d = grant;
          hold_d = '0;
          pend_d = pend_oth & ~(NUM_SRC'(1) << grant);
        end else if (|src_valid) begin
          state_d = ROTATE;
          cur_d = src_valid[cur_q] ? cur_q : nxt_valid;
          dwell_d = '0;
        end else state_d = IDLE;
      end
    end else if (frozen) begin
    end else if (|pend_eff) begin
      state_d = ALERT;
      cur_d = grant;
      hold_d = '0;
      pend_d = pend_eff & ~(NUM_SRC'(1) << grant);
    end else if (!(|src_valid)) state_d = IDLE;
    else if (state_q == IDLE) begin
      state_d = ROTATE;
      cur_d = low_valid;
      dwell_d = '0;
    end else if (!src_valid[cur_q]) begin
      cur_d = nxt_valid;
      dwell_d = '0;
    end else if (tick) begin
      cur_d = dwell_q == CW'(DWELL_TICKS - 1) ? nxt_valid : cur_q;
      dwell_d = dwell_q == CW'(DWELL_TICKS - 1) ? '0 : dwell_q + CW'(1);
    end
  end
  always_comb begin
    number = number_q;
    cur_src = cur_q;
    alert_active = state_q == ALERT;
  end
endmodule

// File: tb/tb_led_display_sched.sv
// tb_led_display_sched: randomized scoreboard bench against a behavioural model of the scheduler.
module tb_led_display_sched;
  localparam int N = 4, PW = 2, DW = 2, HT = 3;
  logic sclk = 0, reset = 1;
  logic [N*16-1:0] src_value = 64'h4444_3333_2222_1111;
  logic [N-1:0] src_valid = '0, src_alert = '0;
  logic [15:0] number;
  logic [1:0] cur_src;
  logic alert_active, tick;
  typedef struct packed {logic [15:0] num; logic [1:0] cur; logic alert; logic tick;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  int m_mode, m_cur, m_dwell, m_hold, m_pc;
  bit [3:0] m_pend;
  bit m_tick;
  logic [15:0] m_num;
  logic [3:0] rv;

  led_display_sched #(.NUM_SRC(N), .SRC_W(2), .PRESCALE_W(PW), .DWELL_TICKS(DW), .HOLD_TICKS(HT)) dut (
    .sclk(sclk), .reset(reset), .src_value(src_value), .src_valid(src_valid), .src_alert(src_alert),
    .number(number), .cur_src(cur_src), .alert_active(alert_active), .tick(tick));

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input int unsigned got, input int unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // First member of set found scanning upward from start, wrapping.
  function automatic int first_from(input bit [3:0] set, input int start);
    for (int k = 0; k < N; k++) if (set[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_cur = 0; m_dwell = 0; m_hold = 0; m_pc = 0; m_pend = 0; m_tick = 0; m_num = 0;
  endfunction

  // Advance the model across one clock edge with the given inputs (0=IDLE,1=ROTATE,2=ALERT).
  function automatic void model_step(input bit [3:0] v, input bit [3:0] a);
    bit [3:0] pe;
    bit t;
    int g;
    pe = m_pend | a;
    t = m_tick;
    m_num = m_mode == 0 ? 16'h0 : src_value[m_cur*16 +: 16];
    m_pend = pe;
    case (m_mode)
      2: begin
        m_pend[m_cur] = 0;
        if (a[m_cur]) m_hold = 0;
        else if (t) begin
          if (m_hold < HT - 1) m_hold++;
          else if (m_pend != 0) begin
            g = first_from(m_pend, 0); m_cur = g; m_hold = 0; m_pend[g] = 0;
          end else if (v != 0) begin
            m_mode = 1; m_dwell = 0;
            if (!v[m_cur]) m_cur = first_from(v, m_cur + 1);
          end else m_mode = 0;
        end
      end
      default: begin
        if (pe != 0) begin
          g = first_from(pe, 0); m_mode = 2; m_cur = g; m_hold = 0; m_pend[g] = 0;
        end else if (v == 0) m_mode = 0;
        else if (m_mode == 0) begin
          m_mode = 1; m_cur = first_from(v, 0); m_dwell = 0;
        end else if (!v[m_cur]) begin
          m_cur = first_from(v, m_cur + 1); m_dwell = 0;
        end else if (t) begin
          m_dwell++;
          if (m_dwell == DW) begin m_dwell = 0; m_cur = first_from(v, m_cur + 1); end
        end
      end
    endcase
    m_tick = m_pc == (1 << PW) - 1;
    m_pc = (m_pc + 1) % (1 << PW);
  endfunction

  task automatic step(input bit [3:0] v, input bit [3:0] a);
    src_valid = v;
    src_alert = a;
    model_step(v, a);
    q.push_back('{m_num, 2'(m_cur), m_mode == 2, m_tick});
    @(posedge sclk);
    #1;
    src_alert = 0;
  endtask

  task automatic run(input int n, input bit [3:0] v);
    repeat (n) step(v, 0);
  endtask

  task automatic do_reset();
    @(negedge sclk);
    #2;
    reset = 1;
    src_alert = 0;
    q.delete();
    #1;
    chk("rst_number", number, 0);
    chk("rst_cur_src", cur_src, 0);
    chk("rst_alert_active", alert_active, 0);
    chk("rst_tick", tick, 0);
    model_reset();
    @(negedge sclk);
    #2;
    reset = 0;
  endtask

  always @(negedge sclk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("number", number, e.num);
      chk("cur_src", cur_src, e.cur);
      chk("alert_active", alert_active, e.alert);
      chk("tick", tick, e.tick);
    end
  end

  initial begin
    do_reset();
    run(100, 4'b0000);
    run(40, 4'b1011);
    for (int i = 0; i < 40 && !(m_mode == 1 && m_cur == 1); i++) step(4'b1011, 0);
    chk("reach_src1", m_cur, 1);
    step(4'b1011, 4'b0100);
    run(30, 4'b1011);
    step(4'b1011, 4'b1010);
    run(5, 4'b1011);
    step(4'b1011, 4'b0010);
    run(40, 4'b1011);
    for (int i = 0; i < 40 && !(m_mode == 1 && m_cur == 1); i++) step(4'b1011, 0);
    run(2, 4'b1011);
    run(6, 4'b1001);
    run(10, 4'b0000);
    step(4'b1111, 4'b0100);
    step(4'b1111, 4'b1000);
    run(2, 4'b1111);
    do_reset();
    run(20, 4'b0000);
    run(20, 4'b0110);
    rv = 4'b1011;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) rv = 4'($urandom);
      if ($urandom_range(0, 49) == 0) src_value = {$urandom, $urandom};
      if (i == 1000) do_reset();
      step(rv, $urandom_range(0, 11) == 0 ? 4'($urandom) : 4'b0000);
    end
    @(negedge sclk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
